nipcb_ahb_master: RTL and testbench

- Single-transfer AHB-Lite initiator.
- Converts a valid/ready command stream (one read or write per command) into AHB-Lite NONSEQ/SINGLE transfers.
- Returns read data and the response status on a valid/ready response stream.
- Drives the register-mapped peripherals (nipcb_ahb and siblings) from bench sequencers, and from on-chip controllers with no CPU.

---
 rtl/nipcb_ahb_master.sv | 130 +++++++++++++
 tb/tb_nipcb_ahb_master.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/nipcb_ahb_master.sv
// Single-transfer AHB-Lite initiator: one valid/ready command becomes one NONSEQ/SINGLE
// transfer; read data and status come back on a held valid/ready response stream.
module nipcb_ahb_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [2:0]            cmd_size,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [2:0]            HBURST,
  output logic                  HMASTLOCK,
  output logic [3:0]            HPROT,
  output logic [2:0]            HSIZE,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [2:0]            size_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [TW-1:0]         to_cnt;
  logic                  accept;
  logic                  illegal;
  logic                  to_hit;

  assign accept  = cmd_valid & cmd_ready;
  assign illegal = (cmd_size > 3'd2)
                 | ((cmd_size == 3'd1) & cmd_addr[0])
                 | ((cmd_size == 3'd2) & (cmd_addr[1:0] != 2'b00));
  // Fires on the HREADY-low edge that would make the wait count reach TIMEOUT_CYCLES.
  assign to_hit  = (TIMEOUT_CYCLES != 0) & (state == DATA) & ~HREADY & (to_cnt == TO_LAST);

  always_ff @(posedge CLK) begin
    if (!RESETn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !illegal) state_nxt = ADDR;
      ADDR:    if (HREADY) state_nxt = DATA;
      DATA:    if (HREADY || to_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE) & ~rsp_valid & RESETn;
    busy      = (state != IDLE) | rsp_valid;
    HTRANS    = (state == ADDR) ? 2'b10 : 2'b00;
  end

  assign HADDR     = addr_q;
  assign HWRITE    = write_q;
  assign HSIZE     = size_q;
  assign HWDATA    = wdata_q;
  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = 4'b0011;

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= 3'b010;
      wdata_q     <= '0;
      to_cnt      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      // Illegal commands never reach the bus, so they leave the address-phase registers alone.
      if (accept && !illegal) begin
        addr_q  <= cmd_addr;
        write_q <= cmd_write;
        size_q  <= cmd_size;
        wdata_q <= cmd_wdata;
      end

      if (state == ADDR)                to_cnt <= '0;
      else if (state == DATA && !HREADY) to_cnt <= to_cnt + TW'(1);

      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;

      if (accept && illegal) begin
        rsp_valid   <= 1'b1;
        rsp_error   <= 1'b1;
        rsp_timeout <= 1'b0;
        rsp_rdata   <= '0;
      end else if (state == DATA && HREADY) begin
        rsp_valid   <= 1'b1;
        rsp_error   <= HRESP;
        rsp_timeout <= 1'b0;
        rsp_rdata   <= (!write_q && !HRESP) ? HRDATA : '0;
      end else if (to_hit) begin
        rsp_valid   <= 1'b1;
        rsp_error   <= 1'b1;
        rsp_timeout <= 1'b1;
        rsp_rdata   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_nipcb_ahb_master.sv
// Bench for nipcb_ahb_master: directed and random commands against a behavioural slave
// and a transaction-level model of expected response, latency and bus usage.
module tb_nipcb_ahb_master;
  localparam int TO = 8;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [2:0]  cmd_size = 3'd2;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_error, rsp_timeout, busy;
  logic [31:0] rsp_rdata, HADDR, HWDATA, HRDATA = '0;
  logic [2:0]  HBURST, HSIZE;
  logic        HMASTLOCK, HWRITE, HREADY = 1'b1, HRESP = 1'b0;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] mem [int];

  always #5 CLK = ~CLK;

  nipcb_ahb_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout), .busy(busy),
    .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(int'(a >> 2))) return mem[int'(a >> 2)];
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    logic [31:0] cur;
    cur = mem_rd(a);
    for (int b = 0; b < 4; b++) begin
      if (sz == 3'd2 || (sz == 3'd1 && b[1] == a[1]) || (sz == 3'd0 && b[1:0] == a[1:0]))
        cur[8*b +: 8] = wd[8*b +: 8];
    end
    mem[int'(a >> 2)] = cur;
  endtask

  function automatic bit is_illegal(input logic [2:0] sz, input logic [31:0] a);
    return (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00);
  endfunction

  // aw/dw: address-phase and data-phase wait states; err: two-cycle ERROR; stuck: HREADY never returns.
  task automatic txn(input bit wr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd,
                     input int aw, input int dw, input bit err, input bit stuck, input int hold);
    bit ill, in_data, exp_err, exp_to;
    logic [31:0] exp_rd;
    int exp_lat, exp_ns, lat, ns, dcnt, guard;
    ill = is_illegal(sz, a);
    exp_rd = '0; exp_err = 1'b1; exp_to = 1'b0; exp_ns = aw + 1;
    if (ill) begin
      exp_lat = 1; exp_ns = 0;
    end else if (stuck) begin
      exp_lat = 2 + aw + TO; exp_to = 1'b1;
    end else if (err) begin
      exp_lat = 4 + aw + dw;
    end else begin
      exp_lat = 3 + aw + dw; exp_err = 1'b0; exp_rd = wr ? 32'h0 : mem_rd(a);
    end

    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge CLK); guard++;
    end
    chk("cmd_ready_before_cmd", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_size = sz; cmd_wdata = wd;
    HREADY = 1'b1; HRESP = 1'b0;
    @(negedge CLK);
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = ~wr;
    lat = 1; ns = 0; dcnt = 0; in_data = 1'b0;
    while (!rsp_valid && lat < 60) begin
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
      if (HTRANS == 2'b10) begin
        ns++;
        chk("haddr", HADDR, a);
        chk("hwrite", {31'b0, HWRITE}, {31'b0, wr});
        chk("hsize", {29'b0, HSIZE}, {29'b0, sz});
        if (ns <= aw) HREADY = 1'b0;
        else in_data = 1'b1;
      end else if (in_data) begin
        dcnt++;
        if (wr) chk("hwdata", HWDATA, wd);
        if (stuck || dcnt <= dw) begin
          HREADY = 1'b0;
        end else if (err && dcnt == dw + 1) begin
          HREADY = 1'b0; HRESP = 1'b1;
        end else begin
          HRESP = err;
          if (!wr) HRDATA = mem_rd(a);
          in_data = 1'b0;
        end
      end
      @(negedge CLK); lat++;
    end
    HREADY = 1'b1; HRESP = 1'b0;
    chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("nonseq_cycles", 32'(ns), 32'(exp_ns));
    chk("rsp_error", {31'b0, rsp_error}, {31'b0, exp_err});
    chk("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, exp_to});
    chk("rsp_rdata", rsp_rdata, exp_rd);

    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      chk("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_rsp_rdata", rsp_rdata, exp_rd);
      chk("hold_rsp_error", {31'b0, rsp_error}, {31'b0, exp_err});
      chk("hold_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      chk("hold_htrans", {30'b0, HTRANS}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    chk("rsp_valid_cleared", {31'b0, rsp_valid}, 32'd0);
    chk("cmd_ready_after_rsp", {31'b0, cmd_ready}, 32'd1);
    chk("busy_after_rsp", {31'b0, busy}, 32'd0);
    if (!ill && !err && !stuck && wr) mem_wr(a, sz, wd);
  endtask

  initial begin
    mem[1] = 32'h1234_5678;

    repeat (3) @(negedge CLK);
    chk("rst_htrans", {30'b0, HTRANS}, 32'd0);
    chk("rst_haddr", HADDR, 32'd0);
    chk("rst_hwrite", {31'b0, HWRITE}, 32'd0);
    chk("rst_hsize", {29'b0, HSIZE}, 32'd2);
    chk("rst_hwdata", HWDATA, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_error", {31'b0, rsp_error}, 32'd0);
    chk("rst_rsp_timeout", {31'b0, rsp_timeout}, 32'd0);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("hburst", {29'b0, HBURST}, 32'd0);
    chk("hmastlock", {31'b0, HMASTLOCK}, 32'd0);
    chk("hprot", {28'b0, HPROT}, 32'h3);
    RESETn = 1'b1;
    @(negedge CLK);
    chk("cmd_ready_out_of_reset", {31'b0, cmd_ready}, 32'd1);

    txn(1'b1, 32'h0C, 3'd2, 32'hDEAD_BEEF, 0, 0, 1'b0, 1'b0, 0);
    txn(1'b0, 32'h04, 3'd2, 32'h0, 0, 3, 1'b0, 1'b0, 0);
    txn(1'b0, 32'h08, 3'd2, 32'h0, 0, 0, 1'b1, 1'b0, 0);
    txn(1'b1, 32'h02, 3'd2, 32'h1111_2222, 0, 0, 1'b0, 1'b0, 0);
    txn(1'b0, 32'h10, 3'd3, 32'h0, 0, 0, 1'b0, 1'b0, 0);
    txn(1'b0, 32'h20, 3'd2, 32'h0, 0, 0, 1'b0, 1'b1, 0);
    txn(1'b0, 32'h0C, 3'd2, 32'h0, 0, 0, 1'b0, 1'b0, 5);
    txn(1'b1, 32'h13, 3'd0, 32'hAB00_0000, 2, 1, 1'b0, 1'b0, 5);
    txn(1'b0, 32'h10, 3'd2, 32'h0, 1, 2, 1'b0, 1'b0, 1);

    for (int k = 0; k < 40; k++) begin
      txn(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), 3'($urandom_range(0, 3)), $urandom,
          int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), $urandom_range(0, 5) == 0,
          $urandom_range(0, 9) == 0, int'($urandom_range(0, 3)));
    end

    // Reset while the address phase is being stretched by the slave.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_size = 3'd2;
    @(negedge CLK);
    cmd_valid = 1'b0;
    chk("mid_rst_nonseq", {30'b0, HTRANS}, 32'h2);
    HREADY = 1'b0;
    @(negedge CLK);
    chk("mid_rst_addr_hold_htrans", {30'b0, HTRANS}, 32'h2);
    chk("mid_rst_addr_hold_haddr", HADDR, 32'h40);
    RESETn = 1'b0; HREADY = 1'b1;
    @(negedge CLK);
    chk("mid_rst_htrans", {30'b0, HTRANS}, 32'd0);
    chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    RESETn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("post_rst_no_rsp", {31'b0, rsp_valid}, 32'd0);
      chk("post_rst_htrans", {30'b0, HTRANS}, 32'd0);
    end
    chk("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    txn(1'b0, 32'h0C, 3'd2, 32'h0, 0, 0, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
